// File: rtl/axi_sts_read_arbiter_pkg.sv
// Shared types and constants for the status-register read arbiter:
// arbiter state encoding, AXI response codes and the grant index width.
package axi_sts_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bits needed to hold a master index; never below 1 so vectors stay legal.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_sts_read_arbiter_if.sv
// Read-channel bundle between the upstream masters, the arbiter and the
// shared status-register slave. s_* signals face the masters (one slice per
// master), m_* signals face the single slave.
interface axi_sts_read_arbiter_if #(
  parameter int NUM_MASTERS    = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);

  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic [NUM_MASTERS-1:0]                s_axi_arvalid;
  logic [NUM_MASTERS-1:0]                s_axi_arready;
  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_axi_rdata;
  logic [NUM_MASTERS*2-1:0]              s_axi_rresp;
  logic [NUM_MASTERS-1:0]                s_axi_rvalid;
  logic [NUM_MASTERS-1:0]                s_axi_rready;

  logic [AXI_ADDR_WIDTH-1:0]             m_axi_araddr;
  logic                                  m_axi_arvalid;
  logic                                  m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]             m_axi_rdata;
  logic [1:0]                            m_axi_rresp;
  logic                                  m_axi_rvalid;
  logic                                  m_axi_rready;

  // View of the requesting masters.
  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  // View of the shared status-register slave.
  modport slave (
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  // View of the arbiter sitting between the two.
  modport arbiter (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

endinterface

// File: rtl/axi_sts_read_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester found when
// scanning upward from last_grant+1, wrapping past NUM_MASTERS-1 to 0.
module axi_sts_rr_pick
  import axi_sts_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GW          = grant_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          last_grant,
  output logic [GW-1:0]          grant,
  output logic                   valid
);

  // Scan offsets 1..NUM_MASTERS; last_grant itself is considered last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!valid && req[j] && (((int'(last_grant) + off) % NUM_MASTERS) == j)) begin
          grant = GW'(j);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_sts_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read-only slave (status
// registers) among NUM_MASTERS read masters, one transaction at a time.
// Optional feature: define STS_ARB_TIMEOUT_EN to add a watchdog that
// answers SLVERR when the slave does not respond within TIMEOUT_CYCLES.
module axi_sts_read_arbiter
  import axi_sts_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi_sts_read_arbiter_if.arbiter bus
);

  localparam int GW = grant_w(NUM_MASTERS);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;

  arb_state_t    state_q, state_n;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_grant_q;
  logic [AW-1:0] addr_q;

  logic [GW-1:0] pick_grant;
  logic          pick_vld;
  logic [AW-1:0] sel_addr;
  logic          gnt_rready;
  logic          txn_done;

  axi_sts_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_pick (
    .req        (bus.s_axi_arvalid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_vld)
  );

  // Address of the master about to be granted, and rready of the current owner.
  always_comb begin
    sel_addr   = '0;
    gnt_rready = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (GW'(i) == pick_grant) sel_addr = bus.s_axi_araddr[i*AW +: AW];
      if (GW'(i) == grant_q)    gnt_rready = bus.s_axi_rready[i];
    end
  end

`ifdef STS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt_q;
  logic          to_hit;

  // Watchdog: cleared while idle (so it starts at zero on entry to ADDR),
  // counts every cycle spent waiting on the slave.
  always_ff @(posedge aclk) begin
    if (areset) begin
      to_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      to_cnt_q <= '0;
    end else if (state_q == ADDR || state_q == DATA) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // True in the last allowed waiting cycle, so ERR is entered exactly
  // TIMEOUT_CYCLES cycles after ADDR was entered.
  assign to_hit = (to_cnt_q >= CW'(TIMEOUT_CYCLES - 1));
`endif

  // Next state and all bus outputs; non-granted slices stay at zero.
  always_comb begin
    state_n            = state_q;
    txn_done           = 1'b0;
    bus.m_axi_arvalid  = 1'b0;
    bus.m_axi_rready   = 1'b0;
    bus.s_axi_arready  = '0;
    bus.s_axi_rvalid   = '0;
    bus.s_axi_rdata    = '0;
    bus.s_axi_rresp    = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) state_n = ADDR;
      end
      ADDR: begin
        bus.m_axi_arvalid = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (GW'(i) == grant_q) bus.s_axi_arready[i] = bus.m_axi_arready;
        end
        if (bus.m_axi_arready) begin
          state_n = DATA;
        end
`ifdef STS_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_n = ERR;
        end
`endif
      end
      DATA: begin
        bus.m_axi_rready = gnt_rready;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (GW'(i) == grant_q) begin
            bus.s_axi_rvalid[i]         = bus.m_axi_rvalid;
            bus.s_axi_rdata[i*DW +: DW] = bus.m_axi_rdata;
            bus.s_axi_rresp[i*2 +: 2]   = bus.m_axi_rresp;
          end
        end
        if (bus.m_axi_rvalid && gnt_rready) begin
          state_n  = IDLE;
          txn_done = 1'b1;
        end
`ifdef STS_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_n = ERR;
        end
`endif
      end
`ifdef STS_ARB_TIMEOUT_EN
      ERR: begin
        // Keep rready high so a late slave response is drained, not replayed.
        bus.m_axi_rready = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (GW'(i) == grant_q) begin
            bus.s_axi_rvalid[i]       = 1'b1;
            bus.s_axi_rresp[i*2 +: 2] = RESP_SLVERR;
          end
        end
        if (gnt_rready) begin
          state_n  = IDLE;
          txn_done = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.m_axi_araddr = addr_q;

  // State, grant and address registers; last_grant moves only on a
  // completed response so an aborted transaction does not shift priority.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      addr_q       <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE && pick_vld) begin
        grant_q <= pick_grant;
        addr_q  <= sel_addr;
      end
      if (txn_done) last_grant_q <= grant_q;
    end
  end

endmodule

// File: tb/tb_axi_sts_read_arbiter.sv
// Directed bench for axi_sts_read_arbiter: single read, full contention,
// response backpressure, reset during DATA and (with STS_ARB_TIMEOUT_EN)
// the watchdog SLVERR path.
module tb_axi_sts_read_arbiter;
  import axi_sts_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_sts_read_arbiter_if #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

  axi_sts_read_arbiter #(
    .NUM_MASTERS    (N),
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int             req_cnt  [N];
  int             issued   [N];
  int             got_cnt  [N];
  logic [DW-1:0]  got_data [N];
  logic [1:0]     got_resp [N];
  logic [AW-1:0]  mst_addr [N];
  logic [N-1:0]   mst_rready;
  int             glog [64];
  int             glog_n     = 0;
  int             arv_cycles = 0;

  logic           slv_ar_en;
  logic           slv_mute;
  logic           srv = 1'b0;
  logic [DW-1:0]  srd = '0;
  logic [1:0]     srr = '0;

  // Slave register contents: 0x8 holds a fixed word, the rest echo the address.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return (a == 32'h8) ? 32'h1234_5678 : {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [1:0] rom_resp(input logic [AW-1:0] a);
    return (a == 32'h40) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_m_arvalid"}, bus.m_axi_arvalid, 0);
    chk({pfx, "_m_rready"},  bus.m_axi_rready, 0);
    chk({pfx, "_m_araddr"},  bus.m_axi_araddr, 0);
    chk({pfx, "_s_arready"}, bus.s_axi_arready, 0);
    chk({pfx, "_s_rvalid"},  bus.s_axi_rvalid, 0);
    chk({pfx, "_s_rdata"},   bus.s_axi_rdata, 0);
    chk({pfx, "_s_rresp"},   bus.s_axi_rresp, 0);
  endtask

  task automatic wait_got(input int i, input int target, input string tag);
    for (int k = 0; k < 60 && got_cnt[i] < target; k++) @(negedge aclk);
    chk(tag, got_cnt[i], target);
  endtask

  // Master-side drive: arvalid held while a request is outstanding.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.s_axi_arvalid[i]         = (issued[i] != req_cnt[i]);
      bus.s_axi_araddr[i*AW +: AW] = mst_addr[i];
    end
  end
  assign bus.s_axi_rready  = mst_rready;

  assign bus.m_axi_arready = slv_ar_en;
  assign bus.m_axi_rvalid  = srv;
  assign bus.m_axi_rdata   = srd;
  assign bus.m_axi_rresp   = srr;

  // Slave model: answers one cycle after the address handshake unless muted.
  always @(posedge aclk) begin
    if (areset) begin
      srv <= 1'b0;
    end else if (bus.m_axi_arvalid && bus.m_axi_arready) begin
      if (!slv_mute) begin
        srv <= 1'b1;
        srd <= rom(bus.m_axi_araddr);
        srr <= rom_resp(bus.m_axi_araddr);
      end
    end else if (srv && bus.m_axi_rready) begin
      srv <= 1'b0;
    end
  end

  // Master monitors: record grant order and captured responses.
  always @(posedge aclk) begin
    if (!areset) begin
      if (bus.m_axi_arvalid) arv_cycles <= arv_cycles + 1;
      for (int i = 0; i < N; i++) begin
        if (bus.s_axi_arvalid[i] && bus.s_axi_arready[i]) begin
          issued[i] <= issued[i] + 1;
          if (glog_n < 64) glog[glog_n] <= i;
          glog_n <= glog_n + 1;
        end
        if (bus.s_axi_rvalid[i] && bus.s_axi_rready[i]) begin
          got_cnt[i]  <= got_cnt[i] + 1;
          got_data[i] <= bus.s_axi_rdata[i*DW +: DW];
          got_resp[i] <= bus.s_axi_rresp[i*2 +: 2];
        end
      end
    end
  end

  initial begin
    int a0;
    int gb;
    int c0;
    int c2;
    int n;
    mst_rready = '1;
    slv_ar_en  = 1'b0;
    slv_mute   = 1'b0;
    for (int i = 0; i < N; i++) mst_addr[i] = '0;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    chk_reset_vals("rst");
    areset = 1'b0;

    // Single read by master 2, slave holds arready low for two cycles.
    mst_addr[2] = 32'h8;
    a0 = arv_cycles;
    req_cnt[2]++;
    @(negedge aclk);
    chk("single_m_arvalid", bus.m_axi_arvalid, 1);
    chk("single_m_araddr", bus.m_axi_araddr, 32'h8);
    chk("single_arready_wait", bus.s_axi_arready, 4'b0000);
    chk("single_rvalid_addr", bus.s_axi_rvalid, 4'b0000);
    @(negedge aclk);
    slv_ar_en = 1'b1;
    #1;
    chk("single_arready_pass", bus.s_axi_arready, 4'b0100);
    @(negedge aclk);
    chk("single_arvalid_drop", bus.m_axi_arvalid, 0);
    chk("single_rvalid", bus.s_axi_rvalid, 4'b0100);
    chk("single_rdata_bus", bus.s_axi_rdata, 128'h0000_0000_1234_5678_0000_0000_0000_0000);
    chk("single_rresp_bus", bus.s_axi_rresp, 0);
    chk("single_m_rready", bus.m_axi_rready, 1);
    @(negedge aclk);
    chk("single_got_cnt", got_cnt[2], 1);
    chk("single_got_data", got_data[2], 32'h1234_5678);
    chk("single_got_resp", got_resp[2], 2'b00);
    chk("single_arv_cycles", arv_cycles - a0, 2);
    chk("single_rvalid_idle", bus.s_axi_rvalid, 4'b0000);

    // Full contention from reset: master 0 asks twice.
    areset = 1'b1;
    mst_addr[0] = 32'h100;
    mst_addr[1] = 32'h104;
    mst_addr[2] = 32'h108;
    mst_addr[3] = 32'h40;
    req_cnt[0] += 2;
    req_cnt[1]++;
    req_cnt[2]++;
    req_cnt[3]++;
    @(negedge aclk);
    areset = 1'b0;
    gb = glog_n;
    c0 = got_cnt[0];
    wait_got(0, c0 + 2, "cont_m0_done");
    chk("cont_order0", glog[gb],     0);
    chk("cont_order1", glog[gb + 1], 1);
    chk("cont_order2", glog[gb + 2], 2);
    chk("cont_order3", glog[gb + 3], 3);
    chk("cont_order4", glog[gb + 4], 0);
    chk("cont_data0", got_data[0], 32'hC0DE_0100);
    chk("cont_data1", got_data[1], 32'hC0DE_0104);
    chk("cont_data2", got_data[2], 32'hC0DE_0108);
    chk("cont_data3", got_data[3], 32'hC0DE_0040);
    chk("cont_resp3", got_resp[3], 2'b10);

    // Backpressure: master 1 withholds rready while master 3 waits.
    gb = glog_n;
    mst_rready[1] = 1'b0;
    mst_addr[1]   = 32'h0C;
    mst_addr[3]   = 32'h44;
    req_cnt[1]++;
    req_cnt[3]++;
    for (int k = 0; k < 20 && !bus.s_axi_rvalid[1]; k++) @(negedge aclk);
    chk("bp_rvalid_seen", bus.s_axi_rvalid[1], 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_m_rready_%0d", k), bus.m_axi_rready, 0);
      chk($sformatf("bp_rvalid_%0d", k), bus.s_axi_rvalid, 4'b0010);
      chk($sformatf("bp_rdata_%0d", k), bus.s_axi_rdata[63:32], 32'hC0DE_000C);
      chk($sformatf("bp_no_grant_%0d", k), bus.m_axi_arvalid, 0);
      @(negedge aclk);
    end
    mst_rready[1] = 1'b1;
    wait_got(3, got_cnt[3] + 1, "bp_m3_done");
    chk("bp_data1", got_data[1], 32'hC0DE_000C);
    chk("bp_data3", got_data[3], 32'hC0DE_0044);
    chk("bp_resp3", got_resp[3], 2'b00);
    chk("bp_order0", glog[gb],     1);
    chk("bp_order1", glog[gb + 1], 3);

    // Reset during DATA: first move last_grant to master 0.
    mst_addr[0] = 32'h14;
    req_cnt[0]++;
    wait_got(0, got_cnt[0] + 1, "rst_pre_m0_done");
    mst_rready[2] = 1'b0;
    mst_addr[2]   = 32'h18;
    c2 = got_cnt[2];
    req_cnt[2]++;
    for (int k = 0; k < 20 && !bus.s_axi_rvalid[2]; k++) @(negedge aclk);
    chk("rst_in_data", bus.s_axi_rvalid[2], 1);
    areset = 1'b1;
    @(negedge aclk);
    chk_reset_vals("rst_mid");
    areset = 1'b0;
    mst_rready[2] = 1'b1;
    gb = glog_n;
    mst_addr[0] = 32'h1C;
    mst_addr[1] = 32'h20;
    req_cnt[0]++;
    req_cnt[1]++;
    wait_got(1, got_cnt[1] + 1, "rst_post_m1_done");
    chk("rst_post_first", glog[gb], 0);
    chk("rst_post_second", glog[gb + 1], 1);
    chk("rst_post_data0", got_data[0], 32'hC0DE_001C);
    chk("rst_dropped", got_cnt[2], c2);

`ifdef STS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers master 1's read.
    slv_mute      = 1'b1;
    mst_rready[1] = 1'b0;
    mst_addr[1]   = 32'h24;
    req_cnt[1]++;
    n = 0;
    while (!bus.s_axi_rvalid[1] && n < 40) begin
      @(negedge aclk);
      n++;
    end
    chk("to_latency", n, 17);
    chk("to_rresp", bus.s_axi_rresp[3:2], 2'b10);
    chk("to_rdata", bus.s_axi_rdata[63:32], 0);
    chk("to_m_rready", bus.m_axi_rready, 1);
    chk("to_m_arvalid", bus.m_axi_arvalid, 0);
    @(negedge aclk);
    chk("to_rvalid_hold", bus.s_axi_rvalid, 4'b0010);
    mst_rready[1] = 1'b1;
    slv_mute      = 1'b0;
    @(negedge aclk);
    chk("to_got_resp", got_resp[1], 2'b10);
    chk("to_got_data", got_data[1], 0);
    mst_addr[2] = 32'h28;
    req_cnt[2]++;
    wait_got(2, got_cnt[2] + 1, "to_next_done");
    chk("to_next_data", got_data[2], 32'hC0DE_0028);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
